// File: rtl/fwd_hazard_scoreboard.sv
// fwd_hazard_scoreboard: EX forward selects, load-use/scoreboard stalls, long-latency write tracking.
// Define FWD_HAZARD_STATS_EN to add saturating stall_cnt_o/luh_cnt_o counters.
module fwd_hazard_scoreboard #(
   parameter int AW         = 5,
   parameter int NUM_SRC    = 2,
   parameter int NUM_STAGES = 2,
   parameter int MAX_OUTST  = 4
) (
   input  logic                                       clk_i,
   input  logic                                       rst_i,
   input  logic [NUM_SRC*AW-1:0]                      ex_src_i,
   input  logic [NUM_SRC*AW-1:0]                      id_src_i,
   input  logic [NUM_SRC-1:0]                         id_src_vld_i,
   input  logic [NUM_STAGES*AW-1:0]                   stg_wreg_i,
   input  logic [NUM_STAGES-1:0]                      stg_wen_i,
   input  logic                                       ex_memread_i,
   input  logic [AW-1:0]                              ex_rd_i,
   input  logic                                       lq_issue_i,
   input  logic [AW-1:0]                              lq_rd_i,
   input  logic                                       lq_done_i,
   input  logic [AW-1:0]                              lq_done_rd_i,
   output logic [NUM_SRC*$clog2(NUM_STAGES+1)-1:0]    fwd_sel_o,
   output logic                                       stall_o,
   output logic                                       bubble_o,
   output logic                                       issue_rdy_o,
   output logic [$clog2(MAX_OUTST+1)-1:0]             outst_o
`ifdef FWD_HAZARD_STATS_EN
   ,
   output logic [31:0]                                stall_cnt_o,
   output logic [31:0]                                luh_cnt_o
`endif
);
   localparam int SEL_W = $clog2(NUM_STAGES+1);
   localparam int CW    = $clog2(MAX_OUTST+1);
   logic [2**AW-1:0] busy;
   logic [CW-1:0]    count;
   logic             luh, sbh, issue_acc, done_acc;
   // Farthest stage first so the nearest matching stage overwrites it.
   always_comb begin
      fwd_sel_o = '0;
      for (int s = 0; s < NUM_SRC; s++)
         for (int k = NUM_STAGES; k >= 1; k--)
            if (stg_wen_i[k-1] && stg_wreg_i[(k-1)*AW +: AW] != '0 &&
                stg_wreg_i[(k-1)*AW +: AW] == ex_src_i[s*AW +: AW])
               fwd_sel_o[s*SEL_W +: SEL_W] = SEL_W'(k);
   end
   always_comb begin
      luh = 1'b0;
      sbh = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
         luh = luh | (ex_memread_i && ex_rd_i != '0 && id_src_vld_i[s] &&
                      id_src_i[s*AW +: AW] == ex_rd_i);
         sbh = sbh | (id_src_vld_i[s] && id_src_i[s*AW +: AW] != '0 &&
                      busy[id_src_i[s*AW +: AW]]);
      end
   end
   assign stall_o     = luh | sbh;
   assign bubble_o    = stall_o;
   assign issue_rdy_o = lq_rd_i == '0 || (count < CW'(MAX_OUTST) && !busy[lq_rd_i]);
   assign issue_acc   = lq_issue_i && issue_rdy_o && lq_rd_i != '0;
   assign done_acc    = lq_done_i && busy[lq_done_rd_i];
   assign outst_o     = count;
   // Set after clear so a same-register issue+complete leaves the register busy.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy  <= '0;
         count <= '0;
      end else begin
         if (done_acc) busy[lq_done_rd_i] <= 1'b0;
         if (issue_acc) busy[lq_rd_i] <= 1'b1;
         count <= count + CW'(issue_acc) - CW'(done_acc);
      end
   end
`ifdef FWD_HAZARD_STATS_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_o <= '0;
         luh_cnt_o   <= '0;
      end else begin
         stall_cnt_o <= stall_cnt_o + 32'(stall_o && stall_cnt_o != '1);
         luh_cnt_o   <= luh_cnt_o + 32'(luh && luh_cnt_o != '1);
      end
   end
`endif
endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// tb_fwd_hazard_scoreboard: directed checks of forwarding, load-use and scoreboard behaviour.
module tb_fwd_hazard_scoreboard;
   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [9:0] ex_src_i, id_src_i, stg_wreg_i;
   logic [1:0] id_src_vld_i, stg_wen_i;
   logic       ex_memread_i, lq_issue_i, lq_done_i;
   logic [4:0] ex_rd_i, lq_rd_i, lq_done_rd_i;
   logic [3:0] fwd_sel_o;
   logic       stall_o, bubble_o, issue_rdy_o;
   logic [2:0] outst_o;
   int         checks = 0;
   int         errors = 0;

   fwd_hazard_scoreboard dut (
      .clk_i(clk_i), .rst_i(rst_i), .ex_src_i(ex_src_i), .id_src_i(id_src_i),
      .id_src_vld_i(id_src_vld_i), .stg_wreg_i(stg_wreg_i), .stg_wen_i(stg_wen_i),
      .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .lq_issue_i(lq_issue_i),
      .lq_rd_i(lq_rd_i), .lq_done_i(lq_done_i), .lq_done_rd_i(lq_done_rd_i),
      .fwd_sel_o(fwd_sel_o), .stall_o(stall_o), .bubble_o(bubble_o),
      .issue_rdy_o(issue_rdy_o), .outst_o(outst_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_i = 1'b1; ex_src_i = '0; id_src_i = '0; stg_wreg_i = '0; id_src_vld_i = '0;
      stg_wen_i = '0; ex_memread_i = 1'b0; lq_issue_i = 1'b0; lq_done_i = 1'b0;
      ex_rd_i = '0; lq_rd_i = '0; lq_done_rd_i = '0;
      tick();
      tick();
      rst_i = 1'b0;
      #1;
      check("rst_outst", outst_o, 0);
      check("rst_stall", stall_o, 0);
      check("rst_bubble", bubble_o, 0);
      check("rst_issue_rdy", issue_rdy_o, 1);
      check("rst_fwd_sel", fwd_sel_o, 0);
      // forwarding priority
      ex_src_i = {5'd0, 5'd3}; stg_wreg_i = {5'd3, 5'd3}; stg_wen_i = 2'b11; #1;
      check("fwd_nearest", fwd_sel_o, 4'b0001);
      stg_wen_i = 2'b10; #1;
      check("fwd_far", fwd_sel_o, 4'b0010);
      ex_src_i = {5'd4, 5'd3}; stg_wreg_i = {5'd4, 5'd3}; stg_wen_i = 2'b11; #1;
      check("fwd_both_src", fwd_sel_o, 4'b1001);
      stg_wen_i = 2'b00; #1;
      check("fwd_no_wen", fwd_sel_o, 0);
      // reg 0 never forwarded
      ex_src_i = '0; stg_wreg_i = '0; stg_wen_i = 2'b11; #1;
      check("fwd_reg0", fwd_sel_o, 0);
      check("fwd_reg0_stall", stall_o, 0);
      stg_wen_i = '0;
      // load-use
      ex_memread_i = 1'b1; ex_rd_i = 5'd7; id_src_i = {5'd7, 5'd0}; id_src_vld_i = 2'b10; #1;
      check("luh_stall", stall_o, 1);
      check("luh_bubble", bubble_o, 1);
      id_src_vld_i = 2'b00; #1;
      check("luh_novld_stall", stall_o, 0);
      check("luh_novld_bubble", bubble_o, 0);
      ex_rd_i = 5'd0; id_src_i = '0; id_src_vld_i = 2'b11; #1;
      check("luh_rd0", stall_o, 0);
      ex_memread_i = 1'b0; ex_rd_i = 5'd7; id_src_i = {5'd7, 5'd7}; #1;
      check("luh_not_load", stall_o, 0);
      id_src_vld_i = '0; id_src_i = '0; ex_rd_i = '0;
      // scoreboard single issue/complete
      lq_issue_i = 1'b1; lq_rd_i = 5'd9; #1;
      check("sb_rdy9", issue_rdy_o, 1);
      tick();
      lq_issue_i = 1'b0; id_src_i = {5'd0, 5'd9}; id_src_vld_i = 2'b01; #1;
      check("sb_stall9", stall_o, 1);
      check("sb_outst1", outst_o, 1);
      check("sb_busy_rdy9", issue_rdy_o, 0);
      lq_done_i = 1'b1; lq_done_rd_i = 5'd9; #1;
      check("sb_same_cycle_done", stall_o, 1);
      tick();
      lq_done_i = 1'b0; #1;
      check("sb_stall_clear", stall_o, 0);
      check("sb_outst0", outst_o, 0);
      id_src_vld_i = '0; id_src_i = '0;
      // fill to MAX_OUTST
      for (int r = 1; r <= 4; r++) begin
         lq_issue_i = 1'b1; lq_rd_i = 5'(r);
         tick();
      end
      lq_rd_i = 5'd5; #1;
      check("full_outst", outst_o, 4);
      check("full_rdy", issue_rdy_o, 0);
      lq_rd_i = 5'd0; #1;
      check("full_rd0_rdy", issue_rdy_o, 1);
      lq_rd_i = 5'd5;
      tick();
      lq_issue_i = 1'b0; id_src_i = {5'd0, 5'd5}; id_src_vld_i = 2'b01; #1;
      check("drop_outst", outst_o, 4);
      check("drop_busy5", stall_o, 0);
      lq_done_i = 1'b1; lq_done_rd_i = 5'd2;
      tick();
      lq_done_i = 1'b0; #1;
      check("done2_outst", outst_o, 3);
      lq_issue_i = 1'b1; lq_rd_i = 5'd5; lq_done_i = 1'b1; lq_done_rd_i = 5'd1; #1;
      check("swap_rdy", issue_rdy_o, 1);
      tick();
      lq_issue_i = 1'b0; lq_done_i = 1'b0; #1;
      check("swap_outst", outst_o, 3);
      check("swap_busy5", stall_o, 1);
      id_src_i = {5'd0, 5'd1}; #1;
      check("swap_busy1", stall_o, 0);
      id_src_i = {5'd4, 5'd0}; id_src_vld_i = 2'b10; #1;
      check("busy4_src1", stall_o, 1);
      lq_done_i = 1'b1; lq_done_rd_i = 5'd20;
      tick();
      lq_done_i = 1'b0; #1;
      check("stray_outst", outst_o, 3);
      // reset with 3 outstanding
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0; #1;
      check("rst2_outst", outst_o, 0);
      check("rst2_stall", stall_o, 0);
      lq_done_i = 1'b1; lq_done_rd_i = 5'd4;
      tick();
      lq_done_i = 1'b0; #1;
      check("rst2_stray", outst_o, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
